// File: rtl/ad9648_pkg.sv
// ad9648_pkg: shared constants for the AD9648 multi-chip capture front-end.
//   - Sequencer state encoding (off / wake / run)
//   - Wake-counter width helper and decimation-counter width
package ad9648_pkg;

  localparam logic [1:0] st_off  = 2'd0;
  localparam logic [1:0] st_wake = 2'd1;
  localparam logic [1:0] st_run  = 2'd2;

  // Decimation ratios up to 256 wrap at 255, so 8 bits always suffice.
  localparam int unsigned decim_cnt_w = 8;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int unsigned wake_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ad9648_chan_cap.sv
// ad9648_chan_cap: two-stage capture of one AD9648 (channels A and B).
//   Optional build macro: OVR_CLAMP_EN (force full-scale codes on overrange).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   load                  stage-2 load strobe (decimated, only in run)
//   run                   high while the sequencer is in run
//   ovr_clr               clears both sticky overrange flags
//   data_a_in/data_b_in   raw ADC buses
//   overrange_a_in/_b_in  raw overrange pins
//   data_a_out/data_b_out registered samples
//   ovr_sticky_a/_b       sticky overrange flags
module ad9648_chan_cap
  import ad9648_pkg::*;
#(
  parameter int unsigned bit_width = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 run,
  input  logic                 ovr_clr,
  input  logic [bit_width-1:0] data_a_in,
  input  logic [bit_width-1:0] data_b_in,
  input  logic                 overrange_a_in,
  input  logic                 overrange_b_in,
  output logic [bit_width-1:0] data_a_out,
  output logic [bit_width-1:0] data_b_out,
  output logic                 ovr_sticky_a,
  output logic                 ovr_sticky_b
);

  logic [bit_width-1:0] s1_a, s1_b;
  logic                 s1_ovr_a, s1_ovr_b;
  logic [bit_width-1:0] sel_a_c, sel_b_c;

  // Sample selected for stage 2: raw code, or full scale in the direction of the MSB.
`ifdef OVR_CLAMP_EN
  assign sel_a_c = s1_ovr_a ? {bit_width{s1_a[bit_width-1]}} : s1_a;
  assign sel_b_c = s1_ovr_b ? {bit_width{s1_b[bit_width-1]}} : s1_b;
`else
  assign sel_a_c = s1_a;
  assign sel_b_c = s1_b;
`endif

  // Stage 1 free-runs; stage 2 loads on the strobe; sticky set beats clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_a         <= '0;
      s1_b         <= '0;
      s1_ovr_a     <= 1'b0;
      s1_ovr_b     <= 1'b0;
      data_a_out   <= '0;
      data_b_out   <= '0;
      ovr_sticky_a <= 1'b0;
      ovr_sticky_b <= 1'b0;
    end else begin
      s1_a     <= data_a_in;
      s1_b     <= data_b_in;
      s1_ovr_a <= overrange_a_in;
      s1_ovr_b <= overrange_b_in;
      if (load) begin
        data_a_out <= sel_a_c;
        data_b_out <= sel_b_c;
      end
      ovr_sticky_a <= (run & s1_ovr_a) | (ovr_sticky_a & ~ovr_clr);
      ovr_sticky_b <= (run & s1_ovr_b) | (ovr_sticky_b & ~ovr_clr);
    end
  end

endmodule

// File: rtl/ad9648_multi_con.sv
// ad9648_multi_con: capture front-end for num_chips AD9648 ADCs on one clock.
//   Optional build macro: OVR_CLAMP_EN (handled inside ad9648_chan_cap).
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   run_en                       1 = power up and stream, 0 = shut down
//   ovr_clr                      pulse, clears all sticky overrange flags
//   enable_n                     per-chip ADC enable (active low, switch together)
//   data_a_in/data_b_in          packed ADC buses, chip k at [k*bit_width +: bit_width]
//   overrange_a_in/_b_in         per-chip overrange pins
//   data_a_out/data_b_out        registered, decimated samples
//   data_valid                   one-cycle strobe when the outputs updated
//   ready                        high while in run
//   ovr_sticky_a/_b              sticky overrange flags
module ad9648_multi_con
  import ad9648_pkg::*;
#(
  parameter int unsigned bit_width   = 14,
  parameter int unsigned num_chips   = 2,
  parameter int unsigned wake_cycles = 1000,
  parameter int unsigned decim_ratio = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run_en,
  input  logic                           ovr_clr,
  output logic [num_chips-1:0]           enable_n,
  input  logic [num_chips*bit_width-1:0] data_a_in,
  input  logic [num_chips*bit_width-1:0] data_b_in,
  input  logic [num_chips-1:0]           overrange_a_in,
  input  logic [num_chips-1:0]           overrange_b_in,
  output logic [num_chips*bit_width-1:0] data_a_out,
  output logic [num_chips*bit_width-1:0] data_b_out,
  output logic                           data_valid,
  output logic                           ready,
  output logic [num_chips-1:0]           ovr_sticky_a,
  output logic [num_chips-1:0]           ovr_sticky_b
);

  localparam int unsigned wcnt_w = wake_cnt_w(wake_cycles);
  localparam logic [wcnt_w-1:0]      wake_last  = wcnt_w'(wake_cycles - 1);
  localparam logic [decim_cnt_w-1:0] decim_last = decim_cnt_w'(decim_ratio - 1);

  logic [1:0]             state_q, state_d;
  logic [wcnt_w-1:0]      wcnt_q, wcnt_d;
  logic [decim_cnt_w-1:0] dcnt_q, dcnt_d;
  logic                   load_c;
  logic                   run_c;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      st_off: begin
        if (run_en) begin
          state_d = st_wake;
          wcnt_d  = '0;
        end
      end
      st_wake: begin
        if (!run_en) begin
          state_d = st_off;
        end else if (wcnt_q == wake_last) begin
          state_d = st_run;
          dcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + wcnt_w'(1);
        end
      end
      st_run: begin
        if (!run_en) begin
          state_d = st_off;
        end else begin
          dcnt_d = (dcnt_q == decim_last) ? '0 : dcnt_q + decim_cnt_w'(1);
        end
      end
      default: state_d = st_off;
    endcase
  end

  assign run_c  = (state_q == st_run);
  // No strobe on the shutdown edge, so data_valid is never high outside run.
  assign load_c = run_c && run_en && (dcnt_q == '0);

  // State, counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= st_off;
      wcnt_q     <= '0;
      dcnt_q     <= '0;
      enable_n   <= '1;
      ready      <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      dcnt_q     <= dcnt_d;
      enable_n   <= {num_chips{state_d == st_off}};
      ready      <= (state_d == st_run);
      data_valid <= load_c;
    end
  end

  for (genvar k = 0; k < num_chips; k++) begin : g_chip
    ad9648_chan_cap #(.bit_width(bit_width)) u_cap (
      .clk            (clk),
      .rst_n          (rst_n),
      .load           (load_c),
      .run            (run_c),
      .ovr_clr        (ovr_clr),
      .data_a_in      (data_a_in[k*bit_width +: bit_width]),
      .data_b_in      (data_b_in[k*bit_width +: bit_width]),
      .overrange_a_in (overrange_a_in[k]),
      .overrange_b_in (overrange_b_in[k]),
      .data_a_out     (data_a_out[k*bit_width +: bit_width]),
      .data_b_out     (data_b_out[k*bit_width +: bit_width]),
      .ovr_sticky_a   (ovr_sticky_a[k]),
      .ovr_sticky_b   (ovr_sticky_b[k])
    );
  end

endmodule

// File: tb/tb_ad9648_multi_con.sv
// tb_ad9648_multi_con: bench for ad9648_multi_con; two instances (decimation 1 and 4)
// share all stimulus. Honours OVR_CLAMP_EN when defined for the build.
module tb_ad9648_multi_con;

  localparam int unsigned bw = 14;
  localparam int unsigned nc = 2;
  localparam int unsigned wk = 8;
`ifdef OVR_CLAMP_EN
  localparam bit clamp_on = 1'b1;
`else
  localparam bit clamp_on = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, run_en, ovr_clr;
  logic [nc*bw-1:0] data_a, data_b;
  logic [nc-1:0]    ovr_a, ovr_b;

  logic [nc-1:0]    en1, en4, sa1, sb1, sa4, sb4;
  logic [nc*bw-1:0] out1_a, out1_b, out4_a, out4_b;
  logic             dv1, dv4, rdy1, rdy4;

  ad9648_multi_con #(.bit_width(bw), .num_chips(nc), .wake_cycles(wk), .decim_ratio(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .ovr_clr(ovr_clr), .enable_n(en1),
    .data_a_in(data_a), .data_b_in(data_b), .overrange_a_in(ovr_a), .overrange_b_in(ovr_b),
    .data_a_out(out1_a), .data_b_out(out1_b), .data_valid(dv1), .ready(rdy1),
    .ovr_sticky_a(sa1), .ovr_sticky_b(sb1));

  ad9648_multi_con #(.bit_width(bw), .num_chips(nc), .wake_cycles(wk), .decim_ratio(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .ovr_clr(ovr_clr), .enable_n(en4),
    .data_a_in(data_a), .data_b_in(data_b), .overrange_a_in(ovr_a), .overrange_b_in(ovr_b),
    .data_a_out(out4_a), .data_b_out(out4_b), .data_valid(dv4), .ready(rdy4),
    .ovr_sticky_a(sa4), .ovr_sticky_b(sb4));

  int errors = 0;
  int checks = 0;

  // Reference model: input history per edge plus the expected held outputs.
  int               cyc = 0;
  bit               in_run = 1'b0;
  int               run_start = 0;
  logic [nc*bw-1:0] hist_a [0:1023];
  logic [nc*bw-1:0] hist_b [0:1023];
  logic [nc-1:0]    hist_oa[0:1023];
  logic [nc-1:0]    hist_ob[0:1023];
  logic [nc*bw-1:0] exp1_a = '0, exp1_b = '0, exp4_a = '0, exp4_b = '0;

  function automatic logic [nc*bw-1:0] model_bus(input logic [nc*bw-1:0] raw, input logic [nc-1:0] ovr);
    logic [nc*bw-1:0] r;
    r = raw;
    for (int k = 0; k < nc; k++)
      if (clamp_on && ovr[k]) r[k*bw +: bw] = raw[k*bw+bw-1] ? {bw{1'b1}} : {bw{1'b0}};
    return r;
  endfunction

  // One clock edge; afterwards the model reflects what the outputs should show.
  task automatic tick();
    logic r, e;
    r = rst_n;
    e = run_en;
    cyc++;
    hist_a[cyc]  = data_a;
    hist_b[cyc]  = data_b;
    hist_oa[cyc] = ovr_a;
    hist_ob[cyc] = ovr_b;
    @(posedge clk);
    #1;
    if (!r) begin
      in_run = 1'b0;
      exp1_a = '0; exp1_b = '0; exp4_a = '0; exp4_b = '0;
    end else if (in_run && !e) begin
      in_run = 1'b0;
    end else if (in_run) begin
      exp1_a = model_bus(hist_a[cyc-1], hist_oa[cyc-1]);
      exp1_b = model_bus(hist_b[cyc-1], hist_ob[cyc-1]);
      if ((cyc - run_start - 1) % 4 == 0) begin
        exp4_a = model_bus(hist_a[cyc-1], hist_oa[cyc-1]);
        exp4_b = model_bus(hist_b[cyc-1], hist_ob[cyc-1]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_en = 1'b0; ovr_clr = 1'b0;
    ovr_a = '0; ovr_b = '0;
    for (int i = 0; i < 3; i++) begin
      data_a = (nc*bw)'($urandom); data_b = (nc*bw)'($urandom);
      tick();
    end
    checks++; if (en1 !== 2'b11 || en4 !== 2'b11) begin errors++; $display("FAIL reset_enable_n: got %b/%b expected 11", en1, en4); end
    checks++; if (rdy1 !== 1'b0 || rdy4 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b expected 0", rdy1, rdy4); end
    checks++; if (dv1 !== 1'b0 || dv4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b expected 0", dv1, dv4); end
    checks++; if (out1_a !== '0 || out1_b !== '0) begin errors++; $display("FAIL reset_data1: got %h/%h expected 0", out1_a, out1_b); end
    checks++; if (out4_a !== '0 || out4_b !== '0) begin errors++; $display("FAIL reset_data4: got %h/%h expected 0", out4_a, out4_b); end
    checks++; if ({sa1, sb1, sa4, sb4} !== '0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", {sa1, sb1, sa4, sb4}); end
  endtask

  task automatic test_wake();
    rst_n = 1'b1;
    tick();
    checks++; if (en1 !== 2'b11) begin errors++; $display("FAIL idle_enable_n: got %b expected 11", en1); end
    run_en = 1'b1;
    tick();
    checks++; if (en1 !== 2'b00 || en4 !== 2'b00) begin errors++; $display("FAIL wake_enable_n: got %b/%b expected 00", en1, en4); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL wake_ready0: got %b expected 0", rdy1); end
    for (int k = 1; k <= int'(wk); k++) begin
      data_a = (nc*bw)'($urandom); data_b = (nc*bw)'($urandom);
      tick();
      checks++; if (rdy1 !== (k == int'(wk)) || rdy4 !== (k == int'(wk))) begin errors++; $display("FAIL wake_ready k=%0d: got %b/%b expected %b", k, rdy1, rdy4, (k == int'(wk))); end
      checks++; if (dv1 !== 1'b0 || dv4 !== 1'b0) begin errors++; $display("FAIL wake_valid k=%0d: got %b/%b expected 0", k, dv1, dv4); end
      checks++; if (en1 !== 2'b00) begin errors++; $display("FAIL wake_hold_enable_n k=%0d: got %b expected 00", k, en1); end
    end
    in_run = 1'b1;
    run_start = cyc;
  endtask

  task automatic test_stream_decim();
    logic [bw-1:0] ramp;
    bit            strobe;
    ramp = bw'($urandom);
    for (int i = 0; i < 24; i++) begin
      data_a = {bw'($urandom), ramp};
      data_b = (nc*bw)'($urandom);
      ramp++;
      tick();
      strobe = ((cyc - run_start - 1) % 4 == 0);
      checks++; if (dv1 !== 1'b1) begin errors++; $display("FAIL stream_valid i=%0d: got %b expected 1", i, dv1); end
      checks++; if (out1_a[bw-1:0] !== hist_a[cyc-1][bw-1:0]) begin errors++; $display("FAIL stream_ramp i=%0d: got %h expected %h", i, out1_a[bw-1:0], hist_a[cyc-1][bw-1:0]); end
      checks++; if (out1_a !== exp1_a || out1_b !== exp1_b) begin errors++; $display("FAIL stream_data i=%0d: got %h/%h expected %h/%h", i, out1_a, out1_b, exp1_a, exp1_b); end
      checks++; if (dv4 !== strobe) begin errors++; $display("FAIL decim_valid i=%0d: got %b expected %b", i, dv4, strobe); end
      checks++; if (out4_a !== exp4_a || out4_b !== exp4_b) begin errors++; $display("FAIL decim_data i=%0d: got %h/%h expected %h/%h", i, out4_a, out4_b, exp4_a, exp4_b); end
    end
  endtask

  task automatic test_overrange();
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    ovr_b = 2'b10; tick(); ovr_b = 2'b00;
    checks++; if (sb1 !== 2'b00) begin errors++; $display("FAIL ovr_latency: got %b expected 00", sb1); end
    tick();
    checks++; if (sb1 !== 2'b10 || sb4 !== 2'b10) begin errors++; $display("FAIL ovr_set: got %b/%b expected 10", sb1, sb4); end
    checks++; if (sa1 !== 2'b00) begin errors++; $display("FAIL ovr_other_chan: got %b expected 00", sa1); end
    tick(); tick();
    checks++; if (sb1 !== 2'b10) begin errors++; $display("FAIL ovr_hold: got %b expected 10", sb1); end
    ovr_b = 2'b10; tick(); ovr_b = 2'b00;
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    checks++; if (sb1 !== 2'b10 || sb4 !== 2'b10) begin errors++; $display("FAIL ovr_set_wins: got %b/%b expected 10", sb1, sb4); end
    tick();
    checks++; if (sb1 !== 2'b10) begin errors++; $display("FAIL ovr_set_wins_hold: got %b expected 10", sb1); end
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    checks++; if (sb1 !== 2'b00 || sb4 !== 2'b00) begin errors++; $display("FAIL ovr_clear: got %b/%b expected 00", sb1, sb4); end
    tick();
    checks++; if (sb1 !== 2'b00) begin errors++; $display("FAIL ovr_clear_hold: got %b expected 00", sb1); end
  endtask

  task automatic test_clamp();
    logic [bw-1:0] e0, e1;
    e0 = clamp_on ? 14'h3FFF : 14'h2001;
    e1 = clamp_on ? 14'h0000 : 14'h0005;
    data_a = {14'h0005, 14'h2001};
    ovr_a = 2'b11;
    tick();
    ovr_a = 2'b00;
    data_a = (nc*bw)'($urandom);
    tick();
    checks++; if (out1_a[bw-1:0] !== e0) begin errors++; $display("FAIL clamp_high: got %h expected %h", out1_a[bw-1:0], e0); end
    checks++; if (out1_a[2*bw-1:bw] !== e1) begin errors++; $display("FAIL clamp_low: got %h expected %h", out1_a[2*bw-1:bw], e1); end
    checks++; if (out1_a !== exp1_a) begin errors++; $display("FAIL clamp_model: got %h expected %h", out1_a, exp1_a); end
    checks++; if (sa1 !== 2'b11 || sa4 !== 2'b11) begin errors++; $display("FAIL clamp_sticky: got %b/%b expected 11", sa1, sa4); end
    tick();
    checks++; if (out1_a !== exp1_a) begin errors++; $display("FAIL clamp_after: got %h expected %h", out1_a, exp1_a); end
  endtask

  task automatic test_shutdown();
    run_en = 1'b0;
    data_a = (nc*bw)'($urandom); data_b = (nc*bw)'($urandom);
    tick();
    checks++; if (en1 !== 2'b11 || en4 !== 2'b11) begin errors++; $display("FAIL off_enable_n: got %b/%b expected 11", en1, en4); end
    checks++; if (rdy1 !== 1'b0 || rdy4 !== 1'b0) begin errors++; $display("FAIL off_ready: got %b/%b expected 0", rdy1, rdy4); end
    checks++; if (dv1 !== 1'b0 || dv4 !== 1'b0) begin errors++; $display("FAIL off_valid: got %b/%b expected 0", dv1, dv4); end
    checks++; if (out1_a !== exp1_a || out4_a !== exp4_a) begin errors++; $display("FAIL off_hold: got %h/%h expected %h/%h", out1_a, out4_a, exp1_a, exp4_a); end
    ovr_b = 2'b11;
    data_a = (nc*bw)'($urandom); data_b = (nc*bw)'($urandom);
    tick();
    ovr_b = 2'b00;
    tick(); tick();
    checks++; if (sb1 !== 2'b00 || sb4 !== 2'b00) begin errors++; $display("FAIL off_no_set: got %b/%b expected 00", sb1, sb4); end
    checks++; if (sa1 !== 2'b11) begin errors++; $display("FAIL off_sticky_keep: got %b expected 11", sa1); end
    checks++; if (out1_b !== exp1_b || out4_b !== exp4_b || dv1 !== 1'b0) begin errors++; $display("FAIL off_hold_late: got %h/%h/%b expected %h/%h/0", out1_b, out4_b, dv1, exp1_b, exp4_b); end
  endtask

  task automatic test_reset_mid_wake();
    run_en = 1'b1;
    tick();
    checks++; if (en1 !== 2'b00) begin errors++; $display("FAIL rewake_enable_n: got %b expected 00", en1); end
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++; if (en1 !== 2'b11 || en4 !== 2'b11) begin errors++; $display("FAIL midrst_enable_n: got %b/%b expected 11", en1, en4); end
    checks++; if (out1_a !== '0 || out1_b !== '0 || out4_a !== '0) begin errors++; $display("FAIL midrst_data: got %h/%h/%h expected 0", out1_a, out1_b, out4_a); end
    checks++; if ({sa1, sa4} !== '0) begin errors++; $display("FAIL midrst_sticky: got %b expected 0", {sa1, sa4}); end
    checks++; if (rdy1 !== 1'b0 || dv1 !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got %b/%b expected 0/0", rdy1, dv1); end
    rst_n = 1'b1;
    tick();
    checks++; if (en1 !== 2'b00) begin errors++; $display("FAIL postrst_wake: got %b expected 00", en1); end
    run_en = 1'b0;
    tick();
    checks++; if (en1 !== 2'b11 || rdy1 !== 1'b0) begin errors++; $display("FAIL wake_abort: got %b/%b expected 11/0", en1, rdy1); end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_stream_decim();
    test_overrange();
    test_clamp();
    test_shutdown();
    test_reset_mid_wake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad9648_multi_con.md
Name: ad9648_multi_con

Overview:
Parametrised capture front-end for N dual-channel AD9648 ADCs on one common sample clock. Sequences each chip's active-low enable through a wake-up delay and registers both channels per chip. Provides optional decimation, valid strobes and sticky overrange flags. Sits between the ADC pins and the downstream DSP/FIFO logic, replacing per-chip unclocked pass-through wrappers.

Parameters:
bit_width, 14, sample width per channel
num_chips, 2, number of AD9648 devices (2 channels each, A/B)
wake_cycles, 1000, clk cycles between enable_n assertion and first accepted sample (>=1)
decim_ratio, 1, output one sample per decim_ratio captured samples (1..256)

Ports:
clk  in  1  common ADC sample clock
rst_n  in  1  synchronous reset, active low
run_en  in  1  level request: 1 = power up and stream, 0 = shut down
ovr_clr  in  1  single-cycle pulse, clears all sticky overrange flags
enable_n  out  num_chips  per-chip ADC enable, active low
data_a_in  in  num_chips*bit_width  channel A buses, chip k at [k*bit_width +: bit_width]
data_b_in  in  num_chips*bit_width  channel B buses, same packing
overrange_a_in  in  num_chips  channel A overrange pins
overrange_b_in  in  num_chips  channel B overrange pins
data_a_out  out  num_chips*bit_width  registered channel A samples
data_b_out  out  num_chips*bit_width  registered channel B samples
data_valid  out  1  one-cycle strobe, outputs updated this cycle
ready  out  1  high while in RUN
ovr_sticky_a  out  num_chips  sticky channel A overrange flags
ovr_sticky_b  out  num_chips  sticky channel B overrange flags

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-low on rst_n. All state updates on the rising edge of clk.
- Reset values: enable_n all 1; data_*_out 0; data_valid 0; ready 0; ovr_sticky_* 0. FSM state = OFF; wake counter and decimation counter = 0.
- FSM states:
  - OFF: enable_n = all 1. run_en=1 -> WAKE, wake counter cleared.
  - WAKE: enable_n = all 0; counter increments each cycle.
    - counter == wake_cycles-1 -> RUN.
    - run_en=0 -> OFF immediately.
  - RUN: enable_n = all 0; ready = 1. run_en=0 -> OFF; ready falls and enable_n rises on the next edge.
- Capture pipeline: stage 1 registers every input bus and overrange pin each cycle, regardless of state. Stage 2 drives the outputs.
- Latency: input sampled at edge n appears on data_*_out with data_valid at edge n+1 (2 registers).
- Decimation:
  - Counter runs only in RUN and wraps at decim_ratio-1.
  - Stage 2 loads, and data_valid pulses, only when the counter == 0. Outputs hold between strobes.
  - decim_ratio=1 gives data_valid continuously high in RUN.
  - The counter resets to 0 on entry to RUN, so the first strobe comes one cycle after ready rises.
- Outside RUN: data_valid = 0; data_*_out hold their last values.
- Overrange:
  - ovr_sticky bit sets when its stage-1 overrange bit is 1 while in RUN, independent of decimation.
  - Cleared by ovr_clr.
  - Simultaneous set and clear: set wins.
- Reset mid-operation returns everything to reset values within one edge. No partial state is retained.
- All chips share one FSM; enable_n bits always switch together.

Optional Feature:
OVR_CLAMP_EN
- Defined: when a channel's stage-1 overrange bit is 1, its output sample is forced to full scale instead of the raw code (offset-binary data).
  - Raw MSB=1 -> all ones.
  - Raw MSB=0 -> all zeros.
- Not defined: raw codes pass unchanged; overrange affects only the sticky flags.

Decomposition:
- Package ad9648_pkg:
  - FSM state encoding (OFF=2'd0, WAKE=2'd1, RUN=2'd2).
  - Wake-counter width function (clog2 of wake_cycles).
  - Decimation-counter width constant (8 bits).
- Sub-module ad9648_chan_cap: one per chip, generate loop.
  - Holds the stage-1/stage-2 registers, sticky flags and clamp logic for both channels.
  - Inputs: load strobe, run flag, ovr_clr.
- Top-level module: FSM, counters, data_valid/ready.

Test Plan:
- Reset/power-up: rst_n low 3 cycles, then run_en=1 with wake_cycles=8 -> enable_n=2'b00 one edge after run_en; ready rises exactly 8 cycles later; data_valid=0 throughout WAKE.
- Streaming latency: decim_ratio=1, drive chip0 A with ramp 0,1,2... -> data_a_out[13:0] equals the input from 2 edges earlier every cycle; data_valid constant 1.
- Decimation: decim_ratio=4, ramp input -> data_valid pulses every 4th cycle; consecutive outputs differ by 4.
- Overrange sticky: pulse overrange_b_in[1] for 1 cycle in RUN -> ovr_sticky_b=2'b10 and holds; ovr_clr in the same cycle as a second pulse -> remains 1; ovr_clr alone -> 0.
- Shutdown/reset mid-run: run_en=0 in RUN -> enable_n=2'b11, ready=0 next edge, outputs hold; rst_n low during WAKE -> all outputs at reset values next edge.
- OVR_CLAMP_EN defined: raw A=14'h2001 with overrange=1 -> output 14'h3FFF; raw 14'h0005 with overrange=1 -> 14'h0000; macro undefined -> raw values pass.
